// File: rtl/fft_sequencer.sv
// fft_sequencer: stage/butterfly issue sequencer for a radix-2 FFT datapath.
// Issues 2^(L-1) butterflies per stage over L stages. After each stage it
// waits PIPE_DEPTH cycles for the butterfly pipeline to drain. It also
// tracks datapath overflow per stage to produce a block scaling exponent.
// Optional feature macro: FFT_SEQ_TIMEOUT_EN. When it is defined, 256
// consecutive stalled RUN cycles abort the run to ERR.
//
//   state | meaning
//   IDLE  | waiting for fft_start_i
//   CHECK | validating the latched log2 length
//   RUN   | issuing butterflies of the current stage
//   DRAIN | waiting PIPE_DEPTH cycles for the pipeline to empty
//   DONE  | one-cycle completion pulse
//   ERR   | one-cycle error pulse (bad length or stall timeout)
module fft_sequencer #(
  parameter int FFT_MAX_LENGTH_LOG2 = 12,
  parameter int PIPE_DEPTH          = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           fft_start_i,
  input  logic                           fft_reset_i,
  input  logic [11:0]                    fft_length_log2_i,
  input  logic                           bfly_ready_i,
  input  logic                           bfly_ovf_i,
  output logic                           bfly_valid_o,
  output logic [3:0]                     stage_o,
  output logic [FFT_MAX_LENGTH_LOG2-2:0] bfly_idx_o,
  output logic                           fft_busy_o,
  output logic                           fft_done_o,
  output logic                           fft_error_o,
  output logic                           overflow_detect_o,
  output logic [3:0]                     scale_exp_o
);

  localparam int IW = FFT_MAX_LENGTH_LOG2 - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [3:0] DRAIN_LOAD = 4'(PIPE_DEPTH - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [11:0]   len_log2;
  logic [3:0]    stage;
  logic [3:0]    stage_last;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_last;
  logic [3:0]    drain_cnt;
  logic          ovf_sticky;
  logic          stage_mark;
  logic [3:0]    scale_exp;
  logic          len_bad;
  logic          tmo_hit;

  // Limits derived from the latched length; only meaningful once CHECK passed.
  assign idx_last   = IW'((32'd1 << (len_log2 - 12'd1)) - 32'd1);
  assign stage_last = len_log2[3:0] - 4'd1;
  assign len_bad    = (len_log2 < 12'd3) || (len_log2 > 12'(FFT_MAX_LENGTH_LOG2));

`ifdef FFT_SEQ_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Stall watchdog: counts down over consecutive not-ready RUN cycles.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      tmo_cnt <= 8'hFF;
    else if (state != S_RUN || bfly_ready_i || fft_reset_i)
      tmo_cnt <= 8'hFF;
    else if (tmo_cnt != 8'd0)
      tmo_cnt <= tmo_cnt - 8'd1;
  end

  assign tmo_hit = (state == S_RUN) && !bfly_ready_i && (tmo_cnt == 8'd0);
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state decode; the synchronous abort overrides every other event.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fft_start_i) state_nxt = S_CHECK;
      S_CHECK: state_nxt = len_bad ? S_ERR : S_RUN;
      S_RUN: begin
        if (tmo_hit)
          state_nxt = S_ERR;
        else if (bfly_ready_i && (idx == idx_last))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == 4'd0)
          state_nxt = (stage == stage_last) ? S_DONE : S_RUN;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (fft_reset_i)
      state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Length latch, stage/idx counters, drain timer and overflow bookkeeping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      len_log2   <= '0;
      stage      <= '0;
      idx        <= '0;
      drain_cnt  <= '0;
      ovf_sticky <= 1'b0;
      stage_mark <= 1'b0;
      scale_exp  <= '0;
    end else if (fft_reset_i) begin
      // scale_exp deliberately survives an abort
      stage      <= '0;
      idx        <= '0;
      drain_cnt  <= '0;
      stage_mark <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fft_start_i) begin
            len_log2   <= fft_length_log2_i;
            ovf_sticky <= 1'b0;
            stage_mark <= 1'b0;
            scale_exp  <= '0;
          end
        end
        S_CHECK: begin
          stage <= '0;
          idx   <= '0;
        end
        S_RUN: begin
          if (bfly_ovf_i) begin
            ovf_sticky <= 1'b1;
            stage_mark <= 1'b1;
          end
          if (bfly_ready_i) begin
            idx <= idx + IW'(1);
            if (idx == idx_last)
              drain_cnt <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (bfly_ovf_i)
            ovf_sticky <= 1'b1;
          if (drain_cnt != 4'd0) begin
            drain_cnt <= drain_cnt - 4'd1;
            if (bfly_ovf_i)
              stage_mark <= 1'b1;
          end else begin
            // overflow seen in the very last drain cycle still marks this stage
            stage_mark <= 1'b0;
            if ((stage_mark || bfly_ovf_i) && (scale_exp != 4'hF))
              scale_exp <= scale_exp + 4'd1;
            if (stage != stage_last) begin
              stage <= stage + 4'd1;
              idx   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bfly_valid_o      = (state == S_RUN);
  assign stage_o           = stage;
  assign bfly_idx_o        = idx;
  assign fft_busy_o        = (state != S_IDLE);
  assign fft_done_o        = (state == S_DONE);
  assign fft_error_o       = (state == S_ERR);
  assign overflow_detect_o = (state == S_DONE) && ovf_sticky;
  assign scale_exp_o       = scale_exp;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer (default parameters).
// Expected behaviour comes from a transaction-level model: the butterfly
// order per stage, a closed-form completion latency plus observed stall
// cycles, and a popcount of the stages that were hit with overflow.
module tb_fft_sequencer;

  localparam int MAXL = 12;
  localparam int PD   = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        fft_start_i = 1'b0;
  logic        fft_reset_i = 1'b0;
  logic [11:0] fft_length_log2_i = '0;
  logic        bfly_ready_i = 1'b0;
  logic        bfly_ovf_i = 1'b0;
  logic        bfly_valid_o;
  logic [3:0]  stage_o;
  logic [10:0] bfly_idx_o;
  logic        fft_busy_o;
  logic        fft_done_o;
  logic        fft_error_o;
  logic        overflow_detect_o;
  logic [3:0]  scale_exp_o;

  int n_checks = 0;
  int n_fails  = 0;

  fft_sequencer #(.FFT_MAX_LENGTH_LOG2(MAXL), .PIPE_DEPTH(PD)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .fft_start_i(fft_start_i),
    .fft_reset_i(fft_reset_i), .fft_length_log2_i(fft_length_log2_i),
    .bfly_ready_i(bfly_ready_i), .bfly_ovf_i(bfly_ovf_i),
    .bfly_valid_o(bfly_valid_o), .stage_o(stage_o), .bfly_idx_o(bfly_idx_o),
    .fft_busy_o(fft_busy_o), .fft_done_o(fft_done_o), .fft_error_o(fft_error_o),
    .overflow_detect_o(overflow_detect_o), .scale_exp_o(scale_exp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 ready random, 3 ready low until cycle 'hold'.
  // mask: stages whose first butterfly slot sees bfly_ovf_i high.
  task automatic run_fft(input int l, input int mode, input int hold, input logic [15:0] mask);
    int  cyc, stalls, hs, per_stage, exp_stage, exp_idx, exp_scale, budget;
    int  prev_stage, prev_idx;
    bit  done_seen, stalled;
    per_stage = 1 << (l - 1);
    exp_scale = 0;
    for (int s = 0; s < l; s++) if (mask[s]) exp_scale++;
    if (exp_scale > 15) exp_scale = 15;
    budget = 4 * (2 + l * (per_stage + PD)) + hold + 100;

    fft_length_log2_i = 12'(l);
    fft_start_i = 1'b1;
    @(negedge clk_i);
    fft_start_i = 1'b0;
    cyc = 1; stalls = 0; hs = 0; exp_stage = 0; exp_idx = 0;
    done_seen = 0; stalled = 0; prev_stage = 0; prev_idx = 0;
    check("scale_cleared_on_start", 32'(scale_exp_o), 32'd0);

    while (!done_seen && cyc < budget) begin
      check("busy_during_run", 32'(fft_busy_o), 32'd1);
      check("no_error_in_run", 32'(fft_error_o), 32'd0);
      if (stalled) begin
        check("stall_hold_stage", 32'(stage_o), 32'(prev_stage));
        check("stall_hold_idx", 32'(bfly_idx_o), 32'(prev_idx));
        stalled = 0;
      end
      if (fft_done_o) begin
        done_seen = 1;
        fft_start_i = 1'b0;
        bfly_ready_i = 1'b0;
        bfly_ovf_i = 1'b0;
        check("done_latency", 32'(cyc), 32'(2 + l * (per_stage + PD) + stalls));
        check("handshake_total", 32'(hs), 32'(l * per_stage));
        check("valid_low_in_done", 32'(bfly_valid_o), 32'd0);
        check("ovf_detect_at_done", 32'(overflow_detect_o), 32'(exp_scale != 0));
        check("scale_at_done", 32'(scale_exp_o), 32'(exp_scale));
      end else begin
        case (mode)
          0:       bfly_ready_i = 1'b1;
          1:       bfly_ready_i = cyc[0];
          2:       bfly_ready_i = ($urandom_range(0, 3) != 0);
          default: bfly_ready_i = (cyc >= hold);
        endcase
        bfly_ovf_i = bfly_valid_o && (bfly_idx_o == 11'd0) && mask[stage_o];
        // start requests while busy must be ignored
        fft_start_i = ($urandom_range(0, 9) == 0);
        fft_length_log2_i = 12'($urandom_range(0, 15));
        if (bfly_valid_o && bfly_ready_i) begin
          check("issue_stage", 32'(stage_o), 32'(exp_stage));
          check("issue_idx", 32'(bfly_idx_o), 32'(exp_idx));
          hs++;
          exp_idx++;
          if (exp_idx == per_stage) begin
            exp_idx = 0;
            exp_stage++;
          end
        end else if (bfly_valid_o) begin
          stalls++;
          stalled = 1;
          prev_stage = int'(stage_o);
          prev_idx = int'(bfly_idx_o);
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    check("done_seen", 32'(done_seen), 32'd1);
    fft_start_i = 1'b0;
    bfly_ready_i = 1'b0;
    bfly_ovf_i = 1'b0;
    @(negedge clk_i);
    check("idle_after_done", 32'(fft_busy_o), 32'd0);
    check("done_one_cycle", 32'(fft_done_o), 32'd0);
    check("ovf_detect_one_cycle", 32'(overflow_detect_o), 32'd0);
    check("scale_held_after_done", 32'(scale_exp_o), 32'(exp_scale));
  endtask

  task automatic run_bad(input int l);
    fft_length_log2_i = 12'(l);
    bfly_ready_i = 1'b1;
    fft_start_i = 1'b1;
    @(negedge clk_i);
    fft_start_i = 1'b0;
    check("bad_c1_busy", 32'(fft_busy_o), 32'd1);
    check("bad_c1_err", 32'(fft_error_o), 32'd0);
    check("bad_c1_valid", 32'(bfly_valid_o), 32'd0);
    @(negedge clk_i);
    check("bad_c2_err", 32'(fft_error_o), 32'd1);
    check("bad_c2_valid", 32'(bfly_valid_o), 32'd0);
    check("bad_c2_done", 32'(fft_done_o), 32'd0);
    @(negedge clk_i);
    check("bad_c3_idle", 32'(fft_busy_o), 32'd0);
    check("bad_c3_err", 32'(fft_error_o), 32'd0);
    bfly_ready_i = 1'b0;
  endtask

  // Abort after k handshakes; stage 0 carries an overflow so scale should read 1.
  task automatic run_abort(input int l, input int k);
    int hs, cyc;
    bit fired;
    hs = 0; cyc = 0; fired = 0;
    fft_length_log2_i = 12'(l);
    fft_start_i = 1'b1;
    @(negedge clk_i);
    fft_start_i = 1'b0;
    while (!fired && cyc < 5000) begin
      bfly_ready_i = 1'b1;
      bfly_ovf_i = bfly_valid_o && (bfly_idx_o == 11'd0) && (stage_o == 4'd0);
      if (bfly_valid_o) hs++;
      if (hs == k) begin
        fft_reset_i = 1'b1;
        fft_start_i = 1'b1;
        fired = 1;
      end
      @(negedge clk_i);
      cyc++;
    end
    check("abort_reached", 32'(fired), 32'd1);
    fft_reset_i = 1'b0;
    fft_start_i = 1'b0;
    bfly_ovf_i = 1'b0;
    check("abort_idle", 32'(fft_busy_o), 32'd0);
    check("abort_valid", 32'(bfly_valid_o), 32'd0);
    check("abort_stage_clr", 32'(stage_o), 32'd0);
    check("abort_idx_clr", 32'(bfly_idx_o), 32'd0);
    check("abort_no_done", 32'(fft_done_o), 32'd0);
    check("abort_no_err", 32'(fft_error_o), 32'd0);
    check("abort_scale_kept", 32'(scale_exp_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("abort_start_ignored", 32'(fft_busy_o), 32'd0);
      check("abort_no_late_done", 32'(fft_done_o), 32'd0);
    end
    bfly_ready_i = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_valid", 32'(bfly_valid_o), 32'd0);
    check("rst_busy", 32'(fft_busy_o), 32'd0);
    check("rst_done", 32'(fft_done_o), 32'd0);
    check("rst_err", 32'(fft_error_o), 32'd0);
    check("rst_stage", 32'(stage_o), 32'd0);
    check("rst_idx", 32'(bfly_idx_o), 32'd0);
    check("rst_scale", 32'(scale_exp_o), 32'd0);
    check("rst_ovf_detect", 32'(overflow_detect_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    run_fft(3, 0, 0, 16'h0000);
    run_bad(2);
    run_bad(13);
    run_bad(0);
    run_bad($urandom_range(14, 4095));
    run_fft(4, 1, 0, 16'h0000);
    run_fft(5, 0, 0, 16'b0000_0000_0000_1010);

    // asynchronous reset takes effect between clock edges
    #2 reset_n_i = 1'b0;
    #1;
    check("async_rst_scale", 32'(scale_exp_o), 32'd0);
    check("async_rst_stage", 32'(stage_o), 32'd0);
    check("async_rst_busy", 32'(fft_busy_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    run_abort(6, $urandom_range(40, 150));

    for (int r = 0; r < 6; r++)
      run_fft($urandom_range(3, 8), $urandom_range(0, 2), 0, 16'($urandom));
    run_fft(12, 0, 0, 16'($urandom));

`ifdef FFT_SEQ_TIMEOUT_EN
    begin
      int cyc, err_cyc;
      fft_length_log2_i = 12'd4;
      bfly_ready_i = 1'b0;
      fft_start_i = 1'b1;
      @(negedge clk_i);
      fft_start_i = 1'b0;
      cyc = 1; err_cyc = 0;
      while (cyc < 400 && err_cyc == 0) begin
        if (fft_error_o) err_cyc = cyc;
        else begin
          @(negedge clk_i);
          cyc++;
        end
      end
      check("timeout_err_cycle", 32'(err_cyc), 32'd258);
      @(negedge clk_i);
      check("timeout_idle", 32'(fft_busy_o), 32'd0);
    end
`else
    run_fft(4, 3, 300, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
